// File: rtl/debounce_array.sv
`default_nettype none
// ============================================================================
// Module   : debounce_array
// Brief    : Multi-channel debouncer for active-low push inputs with
//            press/release pulses and a shared sample prescaler.
// Revision : 1.0 - initial release
// ============================================================================
module debounce_array #(
  parameter int CHANNELS     = 4,
  parameter int STABLE_COUNT = 5,
  parameter int SYNC_STAGES  = 2,
  parameter int SAMPLE_DIV   = 1,
  parameter int MODE         = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic                busy
);

  localparam int c_CNT_W = $clog2(STABLE_COUNT) + 1;
  localparam int c_DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_COUNT - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(SAMPLE_DIV - 1);

  logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
  logic [CHANNELS-1:0] w_s;
  logic [CHANNELS-1:0] w_cnt_nz;
  logic [c_DIV_W-1:0]  r_presc;
  logic                w_tick;
  logic                r_busy;

  // Synchroniser resets to the idle (released) level so no spurious press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
    end else begin
      r_sync[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= '0;
    end else if (r_presc == c_DIV_MAX) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + c_DIV_W'(1);
    end
  end

  assign w_tick = (r_presc == c_DIV_MAX);

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      logic [c_CNT_W-1:0] r_cnt;
      logic [c_CNT_W-1:0] w_cnt_nxt;
      logic               r_dout;
      logic               r_press;
      logic               r_rel;
      logic               w_dout_nxt;
      logic               w_press_nxt;
      logic               w_rel_nxt;

      // In MODE 0 a released sample bypasses the counter entirely
      always_comb begin
        w_cnt_nxt   = r_cnt;
        w_dout_nxt  = r_dout;
        w_press_nxt = 1'b0;
        w_rel_nxt   = 1'b0;
        if (w_tick) begin
          if (w_s[i] == r_dout) begin
            w_cnt_nxt = '0;
          end else if ((MODE == 0 && w_s[i]) || (r_cnt == c_CNT_MAX)) begin
            w_cnt_nxt   = '0;
            w_dout_nxt  = w_s[i];
            w_press_nxt = ~w_s[i];
            w_rel_nxt   = w_s[i];
          end else begin
            w_cnt_nxt = r_cnt + c_CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt   <= '0;
          r_dout  <= 1'b1;
          r_press <= 1'b0;
          r_rel   <= 1'b0;
        end else begin
          r_cnt   <= w_cnt_nxt;
          r_dout  <= w_dout_nxt;
          r_press <= w_press_nxt;
          r_rel   <= w_rel_nxt;
        end
      end

      assign dout[i]          = r_dout;
      assign press[i]         = r_press;
      assign release_pulse[i] = r_rel;
      assign w_cnt_nz[i]      = |r_cnt;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= |w_cnt_nz;
    end
  end

  assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_debounce_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounce_array
// Brief    : Bench for debounce_array; four differently configured instances
//            share one stimulus and are compared to a sample-history model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounce_array;

  localparam int NI = 4;
  localparam int CH = 4;
  localparam int P_STABLE [NI] = '{5, 5, 5, 1};
  localparam int P_SYNC   [NI] = '{2, 2, 2, 3};
  localparam int P_DIV    [NI] = '{1, 1, 4, 1};
  localparam int P_MODE   [NI] = '{0, 1, 0, 1};

  logic          clk;
  logic          reset;
  logic [CH-1:0] din;
  logic [CH-1:0] dout_o  [NI];
  logic [CH-1:0] press_o [NI];
  logic [CH-1:0] rel_o   [NI];
  logic          busy_o  [NI];

  int n_assert = 0;
  int n_fail   = 0;

  // model state: consecutive differing ticks per channel, outputs, din history
  int            run    [NI][CH];
  logic [CH-1:0] m_dout [NI];
  logic [CH-1:0] m_press[NI];
  logic [CH-1:0] m_rel  [NI];
  logic          m_busy [NI];
  logic [CH-1:0] hist   [$];
  int            t;

  generate
    for (genvar k = 0; k < NI; k++) begin : g_dut
      debounce_array #(
        .CHANNELS    (CH),
        .STABLE_COUNT(P_STABLE[k]),
        .SYNC_STAGES (P_SYNC[k]),
        .SAMPLE_DIV  (P_DIV[k]),
        .MODE        (P_MODE[k])
      ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .dout         (dout_o[k]),
        .press        (press_o[k]),
        .release_pulse(rel_o[k]),
        .busy         (busy_o[k])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    t = 0;
    for (int k = 0; k < NI; k++) begin
      m_dout[k]  = '1;
      m_press[k] = '0;
      m_rel[k]   = '0;
      m_busy[k]  = 1'b0;
      for (int c = 0; c < CH; c++) run[k][c] = 0;
    end
  endtask

  // A sample is the din seen SYNC edges earlier; a level change needs
  // STABLE consecutive differing samples, except an immediate release in MODE 0.
  task automatic model_edge();
    logic [CH-1:0] s;
    logic          any;
    hist.push_back(din);
    t++;
    for (int k = 0; k < NI; k++) begin
      any = 1'b0;
      for (int c = 0; c < CH; c++) if (run[k][c] != 0) any = 1'b1;
      m_busy[k]  = any;
      m_press[k] = '0;
      m_rel[k]   = '0;
      if (t % P_DIV[k] == 0) begin
        s = (t > P_SYNC[k]) ? hist[t-1-P_SYNC[k]] : '1;
        for (int c = 0; c < CH; c++) begin
          if (s[c] == m_dout[k][c]) begin
            run[k][c] = 0;
          end else begin
            run[k][c]++;
            if (run[k][c] >= P_STABLE[k] || (P_MODE[k] == 0 && s[c])) begin
              m_dout[k][c] = s[c];
              run[k][c]    = 0;
              if (s[c]) m_rel[k][c] = 1'b1;
              else      m_press[k][c] = 1'b1;
            end
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("dout[%0d]@%0d", k, t), dout_o[k], m_dout[k]);
      chk($sformatf("press[%0d]@%0d", k, t), press_o[k], m_press[k]);
      chk($sformatf("release[%0d]@%0d", k, t), rel_o[k], m_rel[k]);
      chk1($sformatf("busy[%0d]@%0d", k, t), busy_o[k], m_busy[k]);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("%s_dout[%0d]", tag, k), dout_o[k], 4'hF);
      chk($sformatf("%s_press[%0d]", tag, k), press_o[k], 4'h0);
      chk($sformatf("%s_release[%0d]", tag, k), rel_o[k], 4'h0);
      chk1($sformatf("%s_busy[%0d]", tag, k), busy_o[k], 1'b0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    din = '1;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic bounce_busy;
    int   fall_n;
    reset = 1'b0;
    din   = '1;
    model_reset();
    #12;
    check_reset_state("por");
    @(negedge clk);
    reset = 1'b1;

    // reset mid-count: ch0 counter at 3
    din[0] = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk1("midcount_busy_before_reset", busy_o[0], 1'b1);
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_state("midcount");
    @(negedge clk);
    reset = 1'b1;

    // held press after reset: falls on the 7th edge, full count needed again
    for (int n = 1; n <= 12; n++) begin
      step();
      if (n == 6) chk1("press_lat_not_yet", dout_o[0][0], 1'b1);
      if (n == 7) begin
        chk1("press_lat_fall", dout_o[0][0], 1'b0);
        chk1("press_pulse", press_o[0][0], 1'b1);
        chk("press_others_idle", {1'b0, dout_o[0][3:1]}, 4'b0111);
      end
      if (n == 8) chk1("press_pulse_one_cycle", press_o[0][0], 1'b0);
    end
    din[0] = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      step();
      if (n == 2) chk1("mode0_release_not_yet", dout_o[0][0], 1'b0);
      if (n == 3) begin
        chk1("mode0_release_rise", dout_o[0][0], 1'b1);
        chk1("mode0_release_pulse", rel_o[0][0], 1'b1);
      end
    end
    idle(10);

    // bounce on ch1: low 4, high 1, low 4
    bounce_busy = 1'b0;
    for (int n = 0; n < 9; n++) begin
      din[1] = (n == 4) ? 1'b1 : 1'b0;
      step();
      chk1("bounce_dout", dout_o[0][1], 1'b1);
      chk1("bounce_press", press_o[0][1], 1'b0);
      bounce_busy = bounce_busy | busy_o[0];
    end
    din[1] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk1("bounce_dout_tail", dout_o[0][1], 1'b1);
      bounce_busy = bounce_busy | busy_o[0];
    end
    chk1("bounce_busy_seen", bounce_busy, 1'b1);
    idle(5);

    // release glitch on ch2: MODE 0 reacts, MODE 1 ignores
    din[2] = 1'b0;
    for (int n = 0; n < 8; n++) step();
    chk1("glitch_setup_m0", dout_o[0][2], 1'b0);
    chk1("glitch_setup_m1", dout_o[1][2], 1'b0);
    din[2] = 1'b1;
    step();
    din[2] = 1'b0;
    step();
    chk1("glitch_m0_not_yet", dout_o[0][2], 1'b0);
    step();
    chk1("glitch_m0_rise", dout_o[0][2], 1'b1);
    chk1("glitch_m0_release", rel_o[0][2], 1'b1);
    chk1("glitch_m1_ignored", dout_o[1][2], 1'b0);
    for (int n = 0; n < 10; n++) step();
    chk1("glitch_m1_still_low", dout_o[1][2], 1'b0);
    din[2] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (n == 6) chk1("m1_release_not_yet", dout_o[1][2], 1'b0);
      if (n == 7) begin
        chk1("m1_release_rise", dout_o[1][2], 1'b1);
        chk1("m1_release_pulse", rel_o[1][2], 1'b1);
      end
    end
    idle(30);

    // prescaled instance: edges counted once the synchronised sample has turned
    din[0] = 1'b0;
    step();
    step();
    fall_n = 0;
    for (int n = 1; n <= 30; n++) begin
      step();
      if (fall_n == 0 && dout_o[2][0] == 1'b0) fall_n = n;
    end
    chk1("div4_fall_window", (fall_n >= 17 && fall_n <= 20), 1'b1);
    idle(30);

    // all channels pressed in the same cycle
    din = 4'b0000;
    for (int n = 1; n <= 8; n++) begin
      step();
      if (n == 6) chk("all_not_yet", dout_o[0], 4'hF);
      if (n == 7) begin
        chk("all_fall", dout_o[0], 4'h0);
        chk("all_press", press_o[0], 4'hF);
      end
      if (n == 8) chk("all_press_one_cycle", press_o[0], 4'h0);
    end
    idle(30);

    // random bouncing with one asynchronous reset in the middle
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 5) == 0) din[c] = ~din[c];
      if (n == 200) begin
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_reset_state("rand_rst");
        @(negedge clk);
        reset = 1'b1;
      end
      step();
    end
    idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
